fpu_cmd_issuer: RTL

//  Initiator side of the fpu operand/opcode/act/done interface. Accepts one FP command over a valid/ready

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_cmd_timer.sv | 42 ++++
 rtl/fpu_cmd_issuer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, response flag layout and FSM states
// for the fpu command issuer.
package fpu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_MUL  = 3'd1;
   localparam logic [2:0] OP_DIV  = 3'd2;
   localparam logic [2:0] OP_SQRT = 3'd3;
   localparam logic [2:0] OP_CMP  = 3'd4;

   localparam int FLAG_LESS     = 0;
   localparam int FLAG_GREAT    = 1;
   localparam int FLAG_EQ       = 2;
   localparam int FLAG_DIV_ZERO = 3;
   localparam int FLAG_INEXACT  = 4;
   localparam int FLAG_INV      = 5;
   localparam int FLAG_UN       = 6;
   localparam int FLAG_OV       = 7;
   localparam int FLAG_TIMEOUT  = 8;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Compare only reports ordering and invalid; arithmetic flags are forced low.
   localparam logic [8:0] CMP_MASK = 9'b0_0010_0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/fpu_cmd_timer.sv
// Shared cycle counter for the CLR pulse, compare latency
// and done timeout; hits are decoded from the count.
module fpu_cmd_timer #(
   parameter int CW      = 8,
   parameter int CLR_CYC = 1,
   parameter int CMP_LAT = 2,
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rstp,
   input  logic clr_i,
   input  logic en_i,
   output logic clr_hit_o,
   output logic cmp_hit_o,
   output logic to_hit_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rstp) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign clr_hit_o = (cnt_q == CW'(CLR_CYC - 1));
   assign cmp_hit_o = (cnt_q == CW'(CMP_LAT - 1));
   assign to_hit_o  = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Single-outstanding command issuer driving the fpu
// act/done handshake and returning result plus flags.
module fpu_cmd_issuer
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CMP_LAT = 2,
   parameter int CLR_CYC = 1
) (
   input  logic        clk,
   input  logic        rstp,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_opcode,
   input  logic [2:0]  cmd_round,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [8:0]  rsp_flags,
   output logic        busy,
   output logic [31:0] fpu_in1,
   output logic [31:0] fpu_in2,
   output logic [2:0]  fpu_opcode,
   output logic [2:0]  fpu_round,
   output logic        fpu_act,
   output logic        fpu_rst,
   input  logic [31:0] fpu_out,
   input  logic        fpu_done,
   input  logic        fpu_ov,
   input  logic        fpu_un,
   input  logic        fpu_inv,
   input  logic        fpu_inexact,
   input  logic        fpu_div_zero,
   input  logic        fpu_eq,
   input  logic        fpu_great,
   input  logic        fpu_less
);

   localparam int CW = $clog2(TIMEOUT + CMP_LAT + CLR_CYC + 1);

   state_e      state_q;
   logic [31:0] in1_q;
   logic [31:0] in2_q;
   logic [2:0]  op_q;
   logic [2:0]  rm_q;
   logic        act_q;
   logic        rst_q;
   logic        rv_q;
   logic [31:0] data_q;
   logic [8:0]  flags_q;

   logic        clr_hit;
   logic        cmp_hit;
   logic        to_hit;
   logic        tmr_clr;
   logic        tmr_en;
   logic [8:0]  fpu_flags;

   assign fpu_flags = {1'b0, fpu_ov, fpu_un, fpu_inv, fpu_inexact,
                       fpu_div_zero, fpu_eq, fpu_great, fpu_less};

   // Count restarts at zero on the first RUN cycle.
   assign tmr_clr = (state_q == ST_IDLE) ||
                    ((state_q == ST_CLR) && clr_hit);
   assign tmr_en  = (state_q == ST_CLR) || (state_q == ST_RUN);

   fpu_cmd_timer #(
      .CW      (CW),
      .CLR_CYC (CLR_CYC),
      .CMP_LAT (CMP_LAT),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rstp      (rstp),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .clr_hit_o (clr_hit),
      .cmp_hit_o (cmp_hit),
      .to_hit_o  (to_hit)
   );

   always_ff @(posedge clk) begin
      if (rstp) begin
         state_q <= ST_IDLE;
         in1_q   <= '0;
         in2_q   <= '0;
         op_q    <= '0;
         rm_q    <= '0;
         act_q   <= 1'b0;
         rst_q   <= 1'b0;
         rv_q    <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  in1_q   <= cmd_a;
                  in2_q   <= cmd_b;
                  op_q    <= cmd_opcode;
                  rm_q    <= cmd_round;
                  rst_q   <= 1'b1;
                  state_q <= ST_CLR;
               end
            end
            ST_CLR: begin
               if (clr_hit) begin
                  rst_q <= 1'b0;
                  if (op_q > OP_CMP) begin
                     data_q  <= QNAN;
                     flags_q <= 9'(1) << FLAG_INV;
                     rv_q    <= 1'b1;
                     state_q <= ST_RESP;
                  end else begin
                     act_q   <= 1'b1;
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (op_q == OP_CMP) begin
                  if (cmp_hit) begin
                     data_q  <= '0;
                     flags_q <= fpu_flags & CMP_MASK;
                     act_q   <= 1'b0;
                     rv_q    <= 1'b1;
                     state_q <= ST_RESP;
                  end
               end else if (fpu_done) begin
                  data_q  <= fpu_out;
                  flags_q <= fpu_flags;
                  act_q   <= 1'b0;
                  rv_q    <= 1'b1;
                  state_q <= ST_RESP;
               end else if (to_hit) begin
                  data_q  <= QNAN;
                  flags_q <= 9'(1) << FLAG_TIMEOUT;
                  act_q   <= 1'b0;
                  rv_q    <= 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rv_q    <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign rsp_valid  = rv_q;
   assign rsp_data   = data_q;
   assign rsp_flags  = flags_q;
   assign fpu_in1    = in1_q;
   assign fpu_in2    = in2_q;
   assign fpu_opcode = op_q;
   assign fpu_round  = rm_q;
   assign fpu_act    = act_q;
   assign fpu_rst    = rst_q;

endmodule
